// File: rtl/ldo_pass_code_controller.sv
// ldo_pass_code_controller: coarse/fine/lock loop stepping the LDO pass-cell thermometer code.
// The LOCKED state and its toggle counter exist only when LDO_CTRL_LOCK_EN is defined.
module ldo_pass_code_controller #(
    parameter int N_CELLS      = 32,
    parameter int COARSE_STEP  = 4,
    parameter int LOCK_TOGGLES = 4,
    parameter int UNLOCK_RUN   = 3,
    parameter int COARSE_RUN   = 6,
    parameter int INIT_COUNT   = 0
) (
    input  logic                         ldotop_clk,
    input  logic                         ldotop_rst,
    input  logic                         ctrl_en,
    input  logic                         cmp_real,
    input  logic                         cmp_fake,
    output logic [N_CELLS-1:0]           pass_code,
    output logic [$clog2(N_CELLS+1)-1:0] on_count,
    output logic [1:0]                   state,
    output logic                         locked,
    output logic                         sat_hi,
    output logic                         sat_lo
);
    localparam int CW      = $clog2(N_CELLS + 1);
    localparam int SW      = CW + 2;
    localparam int RUN_MAX = COARSE_RUN > UNLOCK_RUN ? COARSE_RUN : UNLOCK_RUN;
    localparam int RW      = $clog2(RUN_MAX + 1);
    localparam logic [CW-1:0] INIT_CNT     = CW'(INIT_COUNT);
    localparam logic [CW-1:0] N_W          = CW'(N_CELLS);
    localparam logic [RW-1:0] RUN_MAX_W    = RW'(RUN_MAX);
    localparam logic [RW-1:0] COARSE_RUN_W = RW'(COARSE_RUN);
    localparam logic [RW-1:0] UNLOCK_W     = RW'(UNLOCK_RUN);

    typedef enum logic [1:0] {OFF = 2'b00, COARSE = 2'b01, FINE = 2'b10, LOCKED = 2'b11} state_t;

    function automatic logic [N_CELLS-1:0] decode(input logic [CW-1:0] c);
        logic [N_CELLS-1:0] r;
        for (int i = 0; i < N_CELLS; i++) r[i] = (i >= int'(c));
        return r;
    endfunction

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d, stepped;
    logic [RW-1:0]      run_q, run_n;
    logic [N_CELLS-1:0] code_q;
    logic               last_dir_q, last_dir_d, last_vld_q, last_vld_d;
    logic               locked_q, sat_hi_q, sat_lo_q;
    logic               valid, up, same, rev, upd, clr, lock_hit;
    logic signed [SW-1:0] mag, sum;

    assign valid = cmp_real ^ cmp_fake;
    assign up    = cmp_real;
    assign same  = last_vld_q && (up == last_dir_q);
    assign rev   = last_vld_q && (up != last_dir_q);
    assign run_n = same ? (run_q == RUN_MAX_W ? run_q : run_q + 1'b1) : RW'(1);

    // Signed wide sum so that stepping past either rail clamps instead of wrapping.
    assign mag     = (state_q == COARSE && !rev) ? SW'(COARSE_STEP) : SW'(1);
    assign sum     = $signed({2'b00, cnt_q}) + (up ? mag : -mag);
    assign stepped = sum[SW-1] ? '0 : (sum > SW'(N_CELLS) ? N_W : sum[CW-1:0]);

`ifdef LDO_CTRL_LOCK_EN
    localparam int TW = $clog2(LOCK_TOGGLES + 1);
    localparam logic [TW-1:0] LOCK_W = TW'(LOCK_TOGGLES);
    logic [TW-1:0] tog_q, tog_n;
    assign tog_n    = !rev ? '0 : (tog_q == LOCK_W ? tog_q : tog_q + 1'b1);
    assign lock_hit = tog_n == LOCK_W;
    always_ff @(posedge ldotop_clk)
        tog_q <= (ldotop_rst || clr) ? '0 : (upd ? tog_n : tog_q);
`else
    assign lock_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_dir_d = last_dir_q;
        last_vld_d = last_vld_q;
        upd        = 1'b0;
        clr        = 1'b0;
        if (!ctrl_en) begin
            state_d    = OFF;
            clr        = 1'b1;
            last_dir_d = 1'b0;
            last_vld_d = 1'b0;
        end else if (state_q == OFF) begin
            state_d = COARSE;
            clr     = 1'b1;
        end else if (valid) begin
            upd        = 1'b1;
            last_dir_d = up;
            last_vld_d = 1'b1;
            cnt_d      = (state_q == LOCKED && run_n != UNLOCK_W) ? cnt_q : stepped;
            if (state_q == COARSE && rev) state_d = FINE;
            else if (state_q == FINE && lock_hit) state_d = LOCKED;
            else if (state_q == FINE && run_n == COARSE_RUN_W) state_d = COARSE;
            else if (state_q == LOCKED && run_n == UNLOCK_W) state_d = FINE;
            clr = state_d != state_q;
        end
    end

    always_ff @(posedge ldotop_clk) begin
        if (ldotop_rst) begin
            state_q    <= OFF;
            cnt_q      <= INIT_CNT;
            code_q     <= decode(INIT_CNT);
            run_q      <= '0;
            last_dir_q <= 1'b0;
            last_vld_q <= 1'b0;
            locked_q   <= 1'b0;
            sat_hi_q   <= INIT_CNT == N_W;
            sat_lo_q   <= INIT_CNT == '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            code_q     <= decode(cnt_d);
            run_q      <= clr ? '0 : (upd ? run_n : run_q);
            last_dir_q <= last_dir_d;
            last_vld_q <= last_vld_d;
            locked_q   <= state_d == LOCKED;
            sat_hi_q   <= cnt_d == N_W;
            sat_lo_q   <= cnt_d == '0;
        end
    end

    assign pass_code = code_q;
    assign on_count  = cnt_q;
    assign state     = state_q;
    assign locked    = locked_q;
    assign sat_hi    = sat_hi_q;
    assign sat_lo    = sat_lo_q;
endmodule

// File: tb/tb_ldo_pass_code_controller.sv
// tb_ldo_pass_code_controller: scoreboard bench against a behavioural loop model.
module tb_ldo_pass_code_controller;
`ifdef LDO_CTRL_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif
    logic        clk = 1'b0, rst, en, cr, cf;
    logic [31:0] pass_code;
    logic [5:0]  on_count;
    logic [1:0]  state;
    logic        locked, sat_hi, sat_lo;

    typedef struct {
        logic [31:0] code;
        int          cnt;
        int          st;
        logic        lk, hi, lo;
    } exp_t;
    exp_t sb[$];

    int total = 0, bad = 0;
    int m_state = 0, m_cnt = 0, m_run = 0, m_tog = 0, m_ld = -1;

    always #5 clk = ~clk;

    ldo_pass_code_controller dut (
        .ldotop_clk(clk), .ldotop_rst(rst), .ctrl_en(en), .cmp_real(cr), .cmp_fake(cf),
        .pass_code(pass_code), .on_count(on_count), .state(state), .locked(locked),
        .sat_hi(sat_hi), .sat_lo(sat_lo)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int clampc(input int v);
        return v < 0 ? 0 : (v > 32 ? 32 : v);
    endfunction

    task automatic model(input logic r_, input logic e_, input logic a, input logic b);
        int d, s, nrun, ntog;
        bit rv;
        if (r_) begin
            m_state = 0; m_cnt = 0; m_run = 0; m_tog = 0; m_ld = -1;
        end else if (!e_) begin
            m_state = 0; m_run = 0; m_tog = 0; m_ld = -1;
        end else if (m_state == 0) begin
            m_state = 1; m_run = 0; m_tog = 0;
        end else if (a != b) begin
            d    = a ? 1 : 0;
            s    = a ? 1 : -1;
            rv   = (m_ld != -1) && (m_ld != d);
            nrun = (m_ld == d) ? (m_run < 6 ? m_run + 1 : 6) : 1;
            ntog = rv ? (m_tog < 4 ? m_tog + 1 : 4) : 0;
            m_ld = d; m_run = nrun; m_tog = ntog;
            if (m_state == 1) begin
                if (rv) begin
                    m_cnt = clampc(m_cnt + s); m_state = 2; m_run = 0; m_tog = 0;
                end else m_cnt = clampc(m_cnt + 4 * s);
            end else if (m_state == 2) begin
                m_cnt = clampc(m_cnt + s);
                if (LOCK && ntog == 4) begin
                    m_state = 3; m_run = 0; m_tog = 0;
                end else if (nrun == 6) begin
                    m_state = 1; m_run = 0; m_tog = 0;
                end
            end else if (nrun == 3) begin
                m_cnt = clampc(m_cnt + s); m_state = 2; m_run = 0; m_tog = 0;
            end
        end
    endtask

    task automatic cyc(input logic r_, input logic e_, input logic a, input logic b);
        exp_t e;
        rst = r_; en = e_; cr = a; cf = b;
        model(r_, e_, a, b);
        for (int i = 0; i < 32; i++) e.code[i] = (i >= m_cnt);
        e.cnt = m_cnt; e.st = m_state; e.lk = (m_state == 3);
        e.hi = (m_cnt == 32); e.lo = (m_cnt == 0);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("code", pass_code, e.code);
        check("cnt", 32'(on_count), 32'(e.cnt));
        check("state", 32'(state), 32'(e.st));
        check("locked", 32'(locked), 32'(e.lk));
        check("sat_hi", 32'(sat_hi), 32'(e.hi));
        check("sat_lo", 32'(sat_lo), 32'(e.lo));
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; cr = 1'b0; cf = 1'b0;
        @(negedge clk);
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        check("rst_code", pass_code, 32'hFFFF_FFFF);
        check("rst_cnt", 32'(on_count), 32'd0);
        check("rst_sat_lo", 32'(sat_lo), 32'd1);
        // up ramp: first enabled cycle only leaves OFF, then +4 per cycle to the rail
        repeat (10) cyc(0, 1, 1, 0);
        check("ramp_cnt", 32'(on_count), 32'd32);
        check("ramp_hi", 32'(sat_hi), 32'd1);
        check("ramp_code", pass_code, 32'h0);
        cyc(1, 0, 0, 0);
        cyc(0, 1, 1, 0);
        repeat (3) cyc(0, 1, 1, 0);
        cyc(0, 1, 0, 1);
        check("rev_cnt", 32'(on_count), 32'd11);
        check("rev_state", 32'(state), 32'd2);
        // drive to FINE around 17 with invalid decisions in between, then lock there
        cyc(1, 0, 0, 0);
        cyc(0, 1, 1, 0);
        repeat (5) cyc(0, 1, 1, 0);
        cyc(0, 1, 0, 1); cyc(0, 1, 0, 1);
        for (int i = 0; i < 5; i++) cyc(0, 1, i[0], i[0]);
        check("inv_cnt", 32'(on_count), 32'd18);
        check("inv_state", 32'(state), 32'd2);
        cyc(0, 1, 0, 1);
        for (int i = 0; i < 4; i++) cyc(0, 1, ~i[0], i[0]);
`ifdef LDO_CTRL_LOCK_EN
        check("lock_state", 32'(state), 32'd3);
        check("lock_flag", 32'(locked), 32'd1);
        check("lock_cnt", 32'(on_count), 32'd17);
`endif
        cyc(0, 1, 1, 0); cyc(0, 1, 0, 1); cyc(0, 1, 1, 0);
        cyc(0, 1, 0, 1); cyc(0, 1, 0, 1);
`ifdef LDO_CTRL_LOCK_EN
        check("hold_cnt", 32'(on_count), 32'd17);
        check("hold_state", 32'(state), 32'd3);
`endif
        cyc(0, 1, 0, 1);
`ifdef LDO_CTRL_LOCK_EN
        check("unlock_cnt", 32'(on_count), 32'd16);
        check("unlock_state", 32'(state), 32'd2);
`endif
        for (int i = 0; i < 4; i++) cyc(0, 1, ~i[0], i[0]);
        cyc(1, 1, 1, 0);
        check("rst2_cnt", 32'(on_count), 32'd0);
        check("rst2_state", 32'(state), 32'd0);
        check("rst2_locked", 32'(locked), 32'd0);
        cyc(0, 1, 1, 0);
        repeat (5) cyc(0, 1, 1, 0);
        cyc(0, 0, 1, 0);
        check("off_state", 32'(state), 32'd0);
        check("off_cnt", 32'(on_count), 32'd20);
        repeat (400) cyc($urandom_range(0, 99) == 0, $urandom_range(0, 24) != 0,
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ldo_pass_code_controller.md
Name: ldo_pass_code_controller

Overview:
- Digital control loop for the 32-cell digital LDO.
- Consumes the clocked comparator decision (the real/fake inverter pair after the RS latch) and steps a thermometer code that drives the pass-transistor gates.
- Sits between the comparator chain and the enable/manual mux that feeds the pass-transistor array.
- Uses coarse/fine search, then locks on a limit cycle.

Parameters:
- N_CELLS, 32: number of pass-transistor cells; width of pass_code.
- COARSE_STEP, 4: cnt step size in COARSE.
- LOCK_TOGGLES, 4: consecutive direction reversals in FINE needed to enter LOCKED.
- UNLOCK_RUN, 3: consecutive same-direction decisions in LOCKED needed to return to FINE.
- COARSE_RUN, 6: consecutive same-direction decisions in FINE needed to return to COARSE.
- INIT_COUNT, 0: cnt value at reset.

Ports:
- ldotop_clk, input, 1: loop clock; same clock as the comparator.
- ldotop_rst, input, 1: reset.
- ctrl_en, input, 1: loop enable.
- cmp_real, input, 1: comparator decision; 1 means vout < ref, so turn more cells on.
- cmp_fake, input, 1: complementary comparator output.
- pass_code, output, N_CELLS: gate code; bit = 0 turns that cell on (PMOS, active-low).
- on_count, output, $clog2(N_CELLS+1): number of cells on (cnt).
- state, output, 2: current FSM state.
- locked, output, 1: high in LOCKED.
- sat_hi, output, 1: high when cnt == N_CELLS.
- sat_lo, output, 1: high when cnt == 0.

Behaviour:
- Clock and reset: one clock, ldotop_clk; reset ldotop_rst is synchronous and active-high.
- Reset values:
  - cnt = INIT_COUNT; pass_code = decode(INIT_COUNT), i.e. all ones for INIT_COUNT = 0.
  - state = OFF (2'b00); locked = 0.
  - run, toggle and last-direction registers cleared; last_dir invalid.
  - sat_hi and sat_lo reflect INIT_COUNT.
- Reset mid-operation overrides everything on that edge.
- Decision sampling:
  - A decision is valid when cmp_real != cmp_fake; direction up = cmp_real.
  - Invalid decisions (equal inputs: precharge or metastable) change nothing. No step, run/toggle counters untouched, last_dir untouched.
- Code decode: pass_code[i] = 0 iff i < cnt. pass_code is registered from next-cnt, so it always matches on_count on the same cycle (no extra latency).
- Step arithmetic:
  - cnt never exceeds N_CELLS nor goes below 0.
  - Saturation clamps the result (e.g. 30 + 4 -> 32; 2 - 4 -> 0).
  - Use a wider intermediate to avoid wrap.
- Run and toggle counting:
  - A valid decision equal to last_dir increments run (saturating) and clears toggle.
  - An opposite decision sets run = 1 and increments toggle.
  - The first decision after entering a state with last_dir invalid sets run = 1, toggle = 0.
- FSM, one step per valid decision:
  - OFF (00):
    - cnt frozen; counters cleared.
    - ctrl_en = 1 -> COARSE next cycle; that cycle's decision is not applied.
  - COARSE (01):
    - Same or first direction: cnt +/- COARSE_STEP.
    - Reversal: cnt +/- 1 in the new direction; go to FINE; clear run/toggle; keep last_dir.
  - FINE (10):
    - cnt +/- 1.
    - When toggle reaches LOCK_TOGGLES -> LOCKED; that step is still applied.
    - When run reaches COARSE_RUN -> COARSE; that step is still applied.
  - LOCKED (11):
    - locked = 1; cnt held.
    - When run reaches UNLOCK_RUN -> FINE, and cnt +/- 1 is applied on that decision.
  - Any state: ctrl_en = 0 -> OFF on the next edge; cnt frozen at its current value; counters and last_dir cleared.
- Saturation: a decision pushing past a limit leaves cnt at the limit but still counts for run/toggle.
- Outputs: all outputs are registered.

Optional Feature:
- Macro: LDO_CTRL_LOCK_EN.
- Defined: LOCKED state as described above.
- Undefined:
  - FINE never transitions to LOCKED; the toggle counter is not implemented.
  - locked is tied to 0; state never reads 2'b11.
  - The FINE -> COARSE transition on COARSE_RUN remains.

Test Plan:
- Reset with INIT_COUNT = 0: ldotop_rst high for 2 cycles -> pass_code = 32'hFFFFFFFF, on_count = 0, state = 00, sat_lo = 1, locked = 0.
- ctrl_en = 1, cmp_real/cmp_fake = 1/0 held:
  - state 01 after 1 cycle.
  - on_count 4, 8, ..., 32 on successive cycles, then holds 32.
  - sat_hi = 1; pass_code = 0.
- COARSE with on_count = 12, one down decision (0/1) -> on_count = 11, state = 10 the next cycle.
- FINE, alternating up/down decisions (LOCK_EN defined):
  - on 4th reversal state = 11, locked = 1.
  - further alternations leave on_count unchanged.
  - Without LOCK_EN: state stays 10 and on_count toggles +/- 1.
- LOCKED at on_count = 17, three consecutive down decisions:
  - on_count stays 17 for the first two.
  - on the third: on_count = 16, state = 10.
- Boundary cases:
  - Inputs 1/1 or 0/0 for 5 cycles in FINE -> no change in on_count, state or counters.
  - ctrl_en drops mid-COARSE at on_count = 20 -> state = 00, on_count stays 20.
  - ldotop_rst pulse in LOCKED -> reset values on the next edge.
